pix_stream_proc: RTL and testbench
==================================

Name: pix_stream_proc

Overview:
- Parametrised successor of the 4-cycle-per-pixel source-to-destination filter sequencer.
- Streams a programmable run of pixels from a synchronous-read source RAM through a selectable grey-level operator into a destination RAM.
- Throughput is one pixel per clock, using a 2-stage pipeline.
- Sits between the two inferred memories and the seven-segment debug path; a host FSM drives it via a start/done handshake.

Parameters:
- ADDR_BITS, 15, width of source/destination addresses and of the length register.
- CH_W, 8, bits per colour channel; a pixel is 3*CH_W bits, packed {R,G,B}.
- RD_LAT, 1, source RAM read latency in cycles (1 or 2 supported).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current run.
- base_addr  in  ADDR_BITS  first pixel address (same offset in src and dst).
- len  in  ADDR_BITS  pixel count; 0 is legal.
- mode  in  2  00 luma, 01 threshold, 10 inverted luma, 11 R-channel copy.
- threshold  in  CH_W  compare level for mode 01.
- src_addr  out  ADDR_BITS  source read address.
- src_data  in  3*CH_W  source read data, valid RD_LAT cycles after src_addr.
- dst_we  out  1  destination write strobe.
- dst_addr  out  ADDR_BITS  destination address.
- dst_data  out  3*CH_W  result pixel {Y,Y,Y}.
- busy  out  1  high from run start until the last write.
- done  out  1  one-cycle pulse after a completed (non-aborted) run.
- pix_cnt  out  ADDR_BITS  number of pixels written in the current/last run.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; src_addr, dst_addr, dst_data, pix_cnt = 0; dst_we, busy, done = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch base_addr, len, mode and threshold; pix_cnt <= 0.
  - If len==0, go to DONE (no write, busy stays 0). Otherwise go to RUN, busy=1.
- RUN:
  - src_addr = base + rd_idx; rd_idx increments every cycle.
  - After issuing index len-1, go to DRAIN.
- DRAIN: wait until all in-flight pixels are written, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Pipeline:
  - The read issued in cycle t returns data in t+RD_LAT.
  - The operator result is registered at the end of that cycle.
  - dst_we, dst_addr and dst_data are driven from registers one cycle after data returns.
  - For RD_LAT=1 with start sampled at edge 0: first src_addr in cycle 1, first dst_we in cycle 3, last dst_we in cycle len+2, done in cycle len+3.
- Operator (all widths exact, no overflow):
  - Y = (R + 2G + B) >> 2, using a CH_W+2-bit adder.
  - Mode 01: Y' = (Y >= threshold) ? all-ones : 0.
  - Mode 10: Y' = ~Y.
  - Mode 11: Y' = R.
- pix_cnt increments on every dst_we.
- Address arithmetic wraps modulo 2^ADDR_BITS; base+len past the top wraps to 0 and is not an error.
- start while busy: ignored; latched config does not change.
- abort: takes effect at the next edge in any state. State goes to IDLE, dst_we=0 from the next cycle, in-flight pixels are discarded, no done pulse, pix_cnt is held.
- abort and start in the same cycle in IDLE: abort wins, no run starts.
- reset mid-run: same as abort, but all outputs take their reset values.

Optional Feature:
- Macro PIX_STREAM_STATS_EN.
  - When defined: adds output hist_hi (ADDR_BITS), counting written pixels with Y >= threshold in any mode. It clears on accepted start and is held after done/abort.
  - When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the mode encodings (MODE_LUMA, MODE_THR, MODE_INV, MODE_RCOPY);
  - the state encoding;
  - the channel-slice helper constants (R/G/B bit offsets as functions of CH_W).
- One sub-module, pix_op: purely combinational Y/Y' operator. It is instantiated once between the read stage and the write register.

Test Plan:
- Luma: len=2, src={0x102030,0xFFFFFF}, mode 00 -> dst_data 0x202020 then 0xFFFFFF; dst_we high cycles 3-4; done in cycle 5; pix_cnt=2.
- Threshold: mode 01, threshold 0x80, same data -> 0x000000, 0xFFFFFF.
- Inverted luma: mode 10, src 0x102030 -> 0xDFDFDF.
- Zero length: len=0 -> no dst_we, busy never high, done one cycle after start.
- Wrap and stray start: base=0x7FFE, len=4 -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001; a second start pulsed mid-run is ignored.
- Abort: abort in cycle 3 of a len=8 run -> dst_we low from cycle 4, no done, state IDLE; a new start is then accepted normally.

Source files
------------

// File: rtl/pix_stream_proc_pkg.sv
// -----------------------------------------------------------------------------
// pix_stream_proc_pkg
// Shared definitions for the pixel stream processor:
//   - mode_t  : grey-level operator selection
//   - state_t : sequencer state encoding
//   - r_lo/g_lo/b_lo : bit offsets of the R/G/B channels in a packed
//                      {R,G,B} pixel, as functions of the channel width
// -----------------------------------------------------------------------------
package pix_stream_proc_pkg;

   typedef enum logic [1:0] {
      MODE_LUMA  = 2'b00,
      MODE_THR   = 2'b01,
      MODE_INV   = 2'b10,
      MODE_RCOPY = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   function automatic int r_lo(input int ch_w);
      return 2 * ch_w;
   endfunction

   function automatic int g_lo(input int ch_w);
      return ch_w;
   endfunction

   function automatic int b_lo(input int ch_w);
      return 0 * ch_w;
   endfunction

endpackage

// File: rtl/pix_stream_proc_op.sv
// -----------------------------------------------------------------------------
// pix_op
// Purely combinational grey-level operator.
//   pix       in  3*CH_W  packed {R,G,B} source pixel
//   mode      in  mode_t  operator selection
//   threshold in  CH_W    compare level (threshold mode and y_hi flag)
//   y_out     out CH_W    operator result Y'
//   y_hi      out 1       luma Y >= threshold, independent of mode
// -----------------------------------------------------------------------------
module pix_op
   import pix_stream_proc_pkg::*;
#(
   parameter int CH_W = 8
) (
   input  logic [3*CH_W-1:0] pix,
   input  mode_t             mode,
   input  logic [CH_W-1:0]   threshold,
   output logic [CH_W-1:0]   y_out,
   output logic              y_hi
);

   localparam int R_LO = r_lo(CH_W);
   localparam int G_LO = g_lo(CH_W);
   localparam int B_LO = b_lo(CH_W);

   logic [CH_W-1:0] r;
   logic [CH_W-1:0] g;
   logic [CH_W-1:0] b;
   logic [CH_W-1:0] y;

   // (R + 2G + B) >> 2; the CH_W+2-bit sum cannot overflow (max 4*(2^CH_W-1)).
   function automatic logic [CH_W-1:0] luma(input logic [CH_W-1:0] r_c,
                                             input logic [CH_W-1:0] g_c,
                                             input logic [CH_W-1:0] b_c);
      logic [CH_W+1:0] sum;
      sum = {2'b00, r_c} + {1'b0, g_c, 1'b0} + {2'b00, b_c};
      return sum[CH_W+1:2];
   endfunction

   always_comb begin
      r     = pix[R_LO +: CH_W];
      g     = pix[G_LO +: CH_W];
      b     = pix[B_LO +: CH_W];
      y     = luma(r, g, b);
      y_hi  = (y >= threshold);
      y_out = y;
      case (mode)
         MODE_THR:   y_out = y_hi ? '1 : '0;
         MODE_INV:   y_out = ~y;
         MODE_RCOPY: y_out = r;
         default:    y_out = y;
      endcase
   end

endmodule

// File: rtl/pix_stream_proc.sv
// -----------------------------------------------------------------------------
// pix_stream_proc
// Streams len pixels from a synchronous-read source RAM through a grey-level
// operator into a destination RAM at one pixel per clock.
//   clk, reset (sync, active-low)
//   start/abort            run control; start sampled only in IDLE
//   base_addr, len, mode, threshold   run configuration, latched on start
//   src_addr / src_data    source RAM read port (data RD_LAT cycles later)
//   dst_we/dst_addr/dst_data  destination RAM write port (registered)
//   busy, done, pix_cnt    status
// Optional: define PIX_STREAM_STATS_EN to add hist_hi, a count of written
// pixels whose luma is >= threshold.
// -----------------------------------------------------------------------------
module pix_stream_proc
   import pix_stream_proc_pkg::*;
#(
   parameter int ADDR_BITS = 15,
   parameter int CH_W      = 8,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [ADDR_BITS-1:0] len,
   input  logic [1:0]           mode,
   input  logic [CH_W-1:0]      threshold,
   output logic [ADDR_BITS-1:0] src_addr,
   input  logic [3*CH_W-1:0]    src_data,
   output logic                 dst_we,
   output logic [ADDR_BITS-1:0] dst_addr,
   output logic [3*CH_W-1:0]    dst_data,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] pix_cnt
`ifdef PIX_STREAM_STATS_EN
   ,
   output logic [ADDR_BITS-1:0] hist_hi
`endif
);

   localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

   state_t               state;
   state_t               state_nxt;
   logic                 start_ok;
   logic                 last_issue;
   logic                 drained;

   logic [ADDR_BITS-1:0] len_q;
   mode_t                mode_q;
   logic [CH_W-1:0]      thr_q;
   logic [ADDR_BITS-1:0] rd_idx;

   // One valid/address slot per cycle of source read latency.
   logic [RD_LAT-1:0]    rd_vld_p;
   logic [ADDR_BITS-1:0] rd_addr_p [RD_LAT];

   logic [CH_W-1:0]      y_op;
   logic                 y_hi;

   assign start_ok = (state == ST_IDLE) && start && !abort;

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // ---- next state / status decode ----
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      last_issue = (rd_idx == (len_q - ONE));
      drained    = ~|rd_vld_p;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (len == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_issue) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            // The last write is on dst_we this cycle once nothing is in flight.
            if (drained) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   // ---- run configuration (data, no reset) ----
   always_ff @(posedge clk) begin
      if (start_ok) begin
         len_q  <= len;
         mode_q <= mode_t'(mode);
         thr_q  <= threshold;
      end
   end

   // ---- stage p0: read issue ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         src_addr <= '0;
         rd_idx   <= '0;
         rd_vld_p <= '0;
      end else begin
         if (start_ok) begin
            src_addr <= base_addr;
            rd_idx   <= '0;
         end else if ((state == ST_RUN) && !abort) begin
            src_addr <= src_addr + ONE;
            rd_idx   <= rd_idx + ONE;
         end
         rd_vld_p[0] <= (state == ST_RUN) && !abort;
         for (int k = 1; k < RD_LAT; k++) rd_vld_p[k] <= rd_vld_p[k-1] && !abort;
      end
   end

   always_ff @(posedge clk) begin
      rd_addr_p[0] <= src_addr;
      for (int k = 1; k < RD_LAT; k++) rd_addr_p[k] <= rd_addr_p[k-1];
   end

   pix_op #(.CH_W(CH_W)) u_op (
      .pix       (src_data),
      .mode      (mode_q),
      .threshold (thr_q),
      .y_out     (y_op),
      .y_hi      (y_hi)
   );

   // ---- stage p1: operator result registered onto the write port ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         dst_we   <= 1'b0;
         dst_addr <= '0;
         dst_data <= '0;
         pix_cnt  <= '0;
      end else begin
         dst_we <= rd_vld_p[RD_LAT-1] && !abort;
         if (rd_vld_p[RD_LAT-1] && !abort) begin
            dst_addr <= rd_addr_p[RD_LAT-1];
            dst_data <= {3{y_op}};
         end
         // A write presented at the abort edge still lands, so it is counted.
         if (start_ok)    pix_cnt <= '0;
         else if (dst_we) pix_cnt <= pix_cnt + ONE;
      end
   end

`ifdef PIX_STREAM_STATS_EN
   logic hi_p1;

   always_ff @(posedge clk) begin
      if (rd_vld_p[RD_LAT-1]) hi_p1 <= y_hi;
   end

   always_ff @(posedge clk) begin
      if (!reset)                hist_hi <= '0;
      else if (start_ok)         hist_hi <= '0;
      else if (dst_we && hi_p1)  hist_hi <= hist_hi + ONE;
   end
`else
   logic stats_unused;
   assign stats_unused = y_hi;
`endif

endmodule

// File: tb/tb_pix_stream_proc.sv
// -----------------------------------------------------------------------------
// tb_pix_stream_proc
// Directed bench for pix_stream_proc (ADDR_BITS=15, CH_W=8, RD_LAT=1) with a
// behavioural synchronous-read source RAM. Cycle n is the cycle after the
// clock edge at which start was sampled (edge 0 -> cycle 1).
// -----------------------------------------------------------------------------
module tb_pix_stream_proc;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [14:0] base_addr;
   logic [14:0] len;
   logic [1:0]  mode;
   logic [7:0]  threshold;
   logic [14:0] src_addr;
   logic [23:0] src_data;
   logic        dst_we;
   logic [14:0] dst_addr;
   logic [23:0] dst_data;
   logic        busy;
   logic        done;
   logic [14:0] pix_cnt;
`ifdef PIX_STREAM_STATS_EN
   logic [14:0] hist_hi;
`endif

   logic [23:0] src_mem [0:32767];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) src_data <= src_mem[src_addr];

   pix_stream_proc #(.ADDR_BITS(15), .CH_W(8), .RD_LAT(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .len       (len),
      .mode      (mode),
      .threshold (threshold),
      .src_addr  (src_addr),
      .src_data  (src_data),
      .dst_we    (dst_we),
      .dst_addr  (dst_addr),
      .dst_data  (dst_data),
      .busy      (busy),
      .done      (done),
      .pix_cnt   (pix_cnt)
`ifdef PIX_STREAM_STATS_EN
      ,
      .hist_hi   (hist_hi)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents start for one edge; returns in cycle 1.
   task automatic go(input logic [14:0] b, input logic [14:0] l,
                     input logic [1:0] m, input logic [7:0] t);
      base_addr = b;
      len       = l;
      mode      = m;
      threshold = t;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) src_mem[i] = 24'h0;
      src_mem[15'h0010] = 24'h102030;
      src_mem[15'h0011] = 24'hFFFFFF;
      src_mem[15'h7FFE] = 24'h3A0000;
      src_mem[15'h7FFF] = 24'h55FFFF;
      src_mem[15'h0000] = 24'h01FF00;
      src_mem[15'h0001] = 24'hC81234;
      for (int i = 0; i < 8; i++) src_mem[15'h0020 + i] = 24'h404040;

      reset = 1'b0; start = 1'b0; abort = 1'b0;
      base_addr = '0; len = '0; mode = 2'b00; threshold = 8'h00;
      repeat (3) tick();

      // ---- reset values ----
      check("rst_dst_we",   dst_we,   0);
      check("rst_busy",     busy,     0);
      check("rst_done",     done,     0);
      check("rst_pix_cnt",  pix_cnt,  0);
      check("rst_src_addr", src_addr, 0);
      check("rst_dst_addr", dst_addr, 0);
      check("rst_dst_data", dst_data, 0);
      reset = 1'b1;
      tick();

      // ---- luma, len=2 ----
      go(15'h0010, 15'd2, 2'b00, 8'h80);
      check("luma_c1_busy", busy, 1);
      check("luma_c1_src_addr", src_addr, 32'h10);
      tick();
      check("luma_c2_src_addr", src_addr, 32'h11);
      check("luma_c2_we", dst_we, 0);
      tick();
      check("luma_c3_we", dst_we, 1);
      check("luma_c3_addr", dst_addr, 32'h10);
      check("luma_c3_data", dst_data, 32'h202020);
      tick();
      check("luma_c4_we", dst_we, 1);
      check("luma_c4_addr", dst_addr, 32'h11);
      check("luma_c4_data", dst_data, 32'hFFFFFF);
      check("luma_c4_busy", busy, 1);
      tick();
      check("luma_c5_done", done, 1);
      check("luma_c5_busy", busy, 0);
      check("luma_c5_we", dst_we, 0);
      check("luma_c5_pix_cnt", pix_cnt, 2);
`ifdef PIX_STREAM_STATS_EN
      check("luma_hist_hi", hist_hi, 1);
`endif
      tick();
      check("luma_c6_done", done, 0);

      // ---- threshold 0x80 ----
      go(15'h0010, 15'd2, 2'b01, 8'h80);
      tick(); tick();
      check("thr_c3_data", dst_data, 32'h000000);
      tick();
      check("thr_c4_data", dst_data, 32'hFFFFFF);
      tick();
      check("thr_c5_done", done, 1);
      tick();

      // ---- inverted luma, len=1 ----
      go(15'h0010, 15'd1, 2'b10, 8'h00);
      tick(); tick();
      check("inv_c3_we", dst_we, 1);
      check("inv_c3_data", dst_data, 32'hDFDFDF);
      tick();
      check("inv_c4_done", done, 1);
      check("inv_c4_pix_cnt", pix_cnt, 1);
      tick();

      // ---- zero length ----
      go(15'h0010, 15'd0, 2'b00, 8'h00);
      check("zero_c1_done", done, 1);
      check("zero_c1_busy", busy, 0);
      check("zero_c1_we", dst_we, 0);
      check("zero_c1_pix_cnt", pix_cnt, 0);
      tick();
      check("zero_c2_done", done, 0);
      check("zero_c2_busy", busy, 0);
      tick();

      // ---- address wrap, R copy, stray start in cycle 2 ----
      go(15'h7FFE, 15'd4, 2'b11, 8'h00);
      base_addr = 15'h0100;
      len       = 15'd1;
      mode      = 2'b00;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      tick();
      check("wrap_c3_addr", dst_addr, 32'h7FFE);
      check("wrap_c3_data", dst_data, 32'h3A3A3A);
      tick();
      check("wrap_c4_addr", dst_addr, 32'h7FFF);
      check("wrap_c4_data", dst_data, 32'h555555);
      tick();
      check("wrap_c5_addr", dst_addr, 32'h0000);
      check("wrap_c5_data", dst_data, 32'h010101);
      tick();
      check("wrap_c6_we", dst_we, 1);
      check("wrap_c6_addr", dst_addr, 32'h0001);
      check("wrap_c6_data", dst_data, 32'hC8C8C8);
      tick();
      check("wrap_c7_done", done, 1);
      check("wrap_c7_pix_cnt", pix_cnt, 4);
      tick();
      check("wrap_c8_done", done, 0);
      check("wrap_c8_busy", busy, 0);
      tick();

      // ---- abort in cycle 3 of a len=8 run ----
      go(15'h0020, 15'd8, 2'b00, 8'h00);
      tick(); tick();
      check("abort_c3_we", dst_we, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_c4_we", dst_we, 0);
      check("abort_c4_busy", busy, 0);
      check("abort_c4_pix_cnt", pix_cnt, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("abort_quiet_we", dst_we, 0);
         check("abort_quiet_done", done, 0);
      end
      check("abort_held_pix_cnt", pix_cnt, 1);
      go(15'h0010, 15'd1, 2'b00, 8'h00);
      check("post_abort_c1_busy", busy, 1);
      tick(); tick();
      check("post_abort_c3_data", dst_data, 32'h202020);
      tick();
      check("post_abort_c4_done", done, 1);
      check("post_abort_c4_pix_cnt", pix_cnt, 1);
      tick();

      // ---- abort and start together in IDLE ----
      abort = 1'b1;
      go(15'h0010, 15'd2, 2'b00, 8'h00);
      abort = 1'b0;
      check("abst_c1_busy", busy, 0);
      check("abst_c1_done", done, 0);
      tick(); tick();
      check("abst_c3_we", dst_we, 0);

      // ---- reset mid-run ----
      go(15'h0010, 15'd4, 2'b00, 8'h00);
      tick(); tick();
      check("rstrun_c3_we", dst_we, 1);
      reset = 1'b0;
      tick();
      check("rstrun_c4_we", dst_we, 0);
      check("rstrun_c4_busy", busy, 0);
      check("rstrun_c4_data", dst_data, 0);
      check("rstrun_c4_addr", dst_addr, 0);
      check("rstrun_c4_src_addr", src_addr, 0);
      check("rstrun_c4_pix_cnt", pix_cnt, 0);
      reset = 1'b1;
      repeat (4) begin
         tick();
         check("rstrun_quiet_done", done, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
